sysbus_mem_responder: RTL and testbench

- Memory-side responder for the Sysbus line-transfer protocol.
- Accepts read and write requests from a fetch/LSU initiator and services them from an internal word array.
- Read: returns one 64-byte line as 8 beats of 64 bits, each beat held until acknowledged.
- Write: consumes 8 data beats.
- Serves as the DRAM model behind the core during simulation; a side port lets the testbench preload the program image.

---
 rtl/sysbus_mem_responder.sv | 152 +++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: serves line reads and writes from an internal word array.
// init_* is a side port for loading the array in any state.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 1024,
    parameter int BEATS          = 8,
    parameter int LATENCY        = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    output logic                         bus_reqack,
    output logic                         bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         bus_respack,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    init_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS);
    localparam int LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic          SYSBUS_READ   = 1'b1;
    localparam logic [3:0]    SYSBUS_MEMORY = 4'h1;

    // IDLE: accept header | WAIT: latency countdown | RESP: stream read beats | WDATA: absorb write beats
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_WDATA
    } state_t;

    state_t                      state_q;
    logic [BW-1:0]               beat_q;
    logic [LW-1:0]               lat_q;
    logic [AW-BW-1:0]            line_q;
    logic [BUS_TAG_WIDTH-1:0]    tag_q;
    logic                        reqack_q;
    logic                        respcyc_q;
    logic [BUS_DATA_WIDTH-1:0]   resp_q;
    logic [BUS_DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

    logic                        accept;
    logic                        req_is_mem;
    logic                        req_is_read;
    logic [AW-BW-1:0]            line_d;
    logic [BW-1:0]               next_beat;
    logic [AW-1:0]               rd_addr;
    logic [BUS_DATA_WIDTH-1:0]   rd_data;
    logic                        bus_wr;

    assign accept      = bus_reqcyc && reqack_q;
    assign req_is_mem  = (bus_reqtag[BUS_TAG_WIDTH-2 -: 4] == SYSBUS_MEMORY);
    assign req_is_read = (bus_reqtag[BUS_TAG_WIDTH-1] == SYSBUS_READ);
    assign line_d      = bus_req[AW+2:BW+3];
    assign next_beat   = beat_q + 1'b1;
    // The first RESP cycle fetches beat 0; afterwards the fetch runs one beat ahead.
    assign rd_addr     = respcyc_q ? {line_q, next_beat} : {line_q, beat_q};
    assign rd_data     = mem_q[rd_addr];
    assign bus_wr      = !reset && (state_q == S_WDATA) && accept;

    // Bus write is issued last so it wins a same-word collision with init.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end
        if (bus_wr) begin
            mem_q[{line_q, beat_q}] <= bus_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            line_q    <= '0;
            tag_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    reqack_q <= 1'b1;
                    if (accept && req_is_mem) begin
                        line_q <= line_d;
                        tag_q  <= bus_reqtag;
                        beat_q <= '0;
                        if (req_is_read) begin
                            reqack_q <= 1'b0;
                            if (LATENCY == 0) begin
                                state_q <= S_RESP;
                            end else begin
                                state_q <= S_WAIT;
                                lat_q   <= LAT_LOAD;
                            end
                        end else begin
                            state_q <= S_WDATA;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (!respcyc_q) begin
                        respcyc_q <= 1'b1;
                        resp_q    <= rd_data;
                    end else if (bus_respack) begin
                        if (beat_q == BW'(BEATS - 1)) begin
                            state_q   <= S_IDLE;
                            reqack_q  <= 1'b1;
                            respcyc_q <= 1'b0;
                            resp_q    <= '0;
                            beat_q    <= '0;
                        end else begin
                            beat_q <= next_beat;
                            resp_q <= rd_data;
                        end
                    end
                end
                S_WDATA: begin
                    if (accept) begin
                        if (beat_q == BW'(BEATS - 1)) begin
                            state_q <= S_IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= next_beat;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = tag_q;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: directed reads/writes, expected beats queued at issue.
module tb_sysbus_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_reqcyc = 1'b0;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack = 1'b1;
    logic        init_we = 1'b0;
    logic [9:0]  init_addr = '0;
    logic [63:0] init_data = '0;

    typedef struct packed {
        logic [12:0] tag;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    sysbus_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .init_we     (init_we),
        .init_addr   (init_addr),
        .init_data   (init_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every response handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus_respcyc && bus_respack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h required=none", bus_resp);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", bus_resp, e.data);
                chk("resp_tag", 64'(bus_resptag), 64'(e.tag));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [63:0] data, input logic [12:0] tag);
        logic got;
        bit   ok;
        ok = 0;
        bus_reqcyc = 1'b1;
        bus_req    = data;
        bus_reqtag = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            got = bus_reqack;
            @(posedge clk);
            if (got) begin
                ok = 1;
                break;
            end
        end
        #1;
        bus_reqcyc = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_reqack required=reqack");
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [12:0] tag, input logic [63:0] start);
        for (int b = 0; b < 8; b++) exp_q.push_back('{tag: tag, data: start + 64'(b)});
    endtask

    task automatic read_line(input string name, input logic [63:0] addr,
                             input logic [12:0] tag, input logic [63:0] start);
        push_line(tag, start);
        send_beat(addr, tag);
        drain(name);
    endtask

    int cnt;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rst_reqack", 64'(bus_reqack), 64'd0);
        chk("rst_resp", bus_resp, 64'd0);
        chk("rst_resptag", 64'(bus_resptag), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            init_we   = 1'b1;
            init_addr = 10'(i);
            init_data = 64'h1000 + 64'(i);
            @(posedge clk);
            #1;
        end
        init_we = 1'b0;

        // Basic read with latency measurement and backpressure on beat 3.
        push_line(13'h1101, 64'h1000);
        send_beat(64'h0, 13'h1101);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_respcyc) break;
            @(posedge clk);
            cnt++;
        end
        chk("latency_cycles", 64'(cnt), 64'd3);
        repeat (3) @(posedge clk);
        #1;
        bus_respack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_resp_hold", bus_resp, 64'h1003);
            chk("bp_respcyc_hold", 64'(bus_respcyc), 64'd1);
            @(posedge clk);
            #1;
        end
        bus_respack = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_next_beat", bus_resp, 64'h1004);
        drain("basic_drain");

        read_line("unaligned_drain", 64'h48, 13'h1102, 64'h1008);

        // Write line at 0x40; no response may appear.
        send_beat(64'h40, 13'h0103);
        for (int b = 0; b < 8; b++) send_beat(64'hA0 + 64'(b), 13'h0103);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_respcyc) cnt++;
        end
        chk("write_no_resp", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        read_line("wr_rd_drain", 64'h40, 13'h1104, 64'hA0);

        read_line("wrap_drain", 64'h2000, 13'h1105, 64'h1000);

        // Reset after beat 4 of a read.
        push_line(13'h1106, 64'h1000);
        send_beat(64'h0, 13'h1106);
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 3) break;
            @(posedge clk);
            #1;
        end
        chk("mid_burst_beats_left", 64'(exp_q.size()), 64'd3);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_respcyc", 64'(bus_respcyc), 64'd0);
        @(posedge clk);
        #1;
        read_line("post_rst_drain", 64'h0, 13'h1107, 64'h1000);

        // Non-memory target: acknowledged, never answered.
        send_beat(64'h0, 13'h1208);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_respcyc) cnt++;
        end
        chk("nonmem_no_resp", 64'(cnt), 64'd0);
        chk("nonmem_idle_reqack", 64'(bus_reqack), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
